// File: rtl/reversi_pkg.sv
// Shared Reversi definitions: cell encoding, board size, direction table and
// the move-validator state encoding. The flip stage reuses the direction
// indices and delta table so that flip_mask bit d means the same thing in both blocks.
package reversi_pkg;

  localparam int BOARD_DIM = 8;

  // Cell contents as returned by the board read port. 2'b11 is reserved and
  // is treated as a blocking (non-capturable) cell.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  // Direction indices; bit d of a flip mask refers to direction d.
  // Rows grow downwards, so north is dy = -1.
  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;

  typedef enum logic [2:0] {
    MV_IDLE,
    MV_RD_ORG,
    MV_EV_ORG,
    MV_STEP,
    MV_EVAL,
    MV_NEXT,
    MV_FINISH
  } mv_state_e;

  function automatic delta_t dir_delta(input logic [2:0] dir);
    delta_t d;
    d.dx = 2'sd0;
    d.dy = 2'sd0;
    case (dir)
      DIR_N:   begin d.dx =  2'sd0; d.dy = -2'sd1; end
      DIR_NE:  begin d.dx =  2'sd1; d.dy = -2'sd1; end
      DIR_E:   begin d.dx =  2'sd1; d.dy =  2'sd0; end
      DIR_SE:  begin d.dx =  2'sd1; d.dy =  2'sd1; end
      DIR_S:   begin d.dx =  2'sd0; d.dy =  2'sd1; end
      DIR_SW:  begin d.dx = -2'sd1; d.dy =  2'sd1; end
      DIR_W:   begin d.dx = -2'sd1; d.dy =  2'sd0; end
      default: begin d.dx = -2'sd1; d.dy = -2'sd1; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/move_validator.sv
// Checks a candidate Reversi move by walking all 8 directions through a synchronous board read port.
// Latency: done 3 cycles after launch for an occupied origin, at most 130 cycles in the worst case.
// Backpressure: none; start is a level, a rising edge in IDLE launches, and start is ignored while busy.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   start                level enable; its rising edge launches a check
//   cursor_x/cursor_y    candidate cell (0,0 = top-left), sampled at launch
//   player               0 = black to move, 1 = white to move, sampled at launch
//   rd_x/rd_y, rd_data   board read port; rd_data is valid one cycle after the address
//   busy                 high from launch until done
//   done                 one-cycle pulse when valid_move/flip_mask are final
//   valid_move           move is legal (held until next launch)
//   flip_mask            bit d set = direction d captures (held until next launch)
module move_validator
  import reversi_pkg::*;
#(
  parameter int BOARD_BITS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BOARD_BITS-1:0] cursor_x,
  input  logic [BOARD_BITS-1:0] cursor_y,
  input  logic                  player,
  output logic [BOARD_BITS-1:0] rd_x,
  output logic [BOARD_BITS-1:0] rd_y,
  input  logic [1:0]            rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  valid_move,
  output logic [7:0]            flip_mask
);

  // One extra bit so a step off either edge shows up in the top bit.
  localparam int W = BOARD_BITS + 1;

  mv_state_e             state_q, state_d;
  logic                  start_q;
  logic [BOARD_BITS-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic                  player_q, player_d;
  logic [BOARD_BITS-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [2:0]            dir_q, dir_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            mask_q, mask_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [BOARD_BITS-1:0] rd_x_q, rd_y_q;

  logic                  launch;
  logic [1:0]            own_cell, opp_cell;
  delta_t                dl;
  logic [W-1:0]          nxt_x, nxt_y;
  logic                  oob;

  assign launch   = start && !start_q;
  assign own_cell = player_q ? CELL_WHITE : CELL_BLACK;
  assign opp_cell = player_q ? CELL_BLACK : CELL_WHITE;

  // Neighbour of pos in the current direction. Going below 0 wraps to a value
  // with the top bit set, as does stepping past the last column/row, so the
  // top bit alone flags out-of-bounds.
  assign dl    = dir_delta(dir_q);
  assign nxt_x = {1'b0, pos_x_q} + {{(W-2){dl.dx[1]}}, dl.dx};
  assign nxt_y = {1'b0, pos_y_q} + {{(W-2){dl.dy[1]}}, dl.dy};
  assign oob   = nxt_x[W-1] | nxt_y[W-1];

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    player_d = player_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    rd_x     = rd_x_q;
    rd_y     = rd_y_q;
    done     = 1'b0;

    case (state_q)
      MV_IDLE: begin
        if (launch) begin
          cur_x_d  = cursor_x;
          cur_y_d  = cursor_y;
          player_d = player;
          mask_d   = 8'h00;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = MV_RD_ORG;
        end
      end

      MV_RD_ORG: begin
        rd_x    = cur_x_q;
        rd_y    = cur_y_q;
        state_d = MV_EV_ORG;
      end

      MV_EV_ORG: begin
        // Any non-empty origin (including reserved) is illegal; mask stays 0.
        if (rd_data != CELL_EMPTY) begin
          state_d = MV_FINISH;
        end else begin
          dir_d   = DIR_N;
          pos_x_d = cur_x_q;
          pos_y_d = cur_y_q;
          cnt_d   = 3'd0;
          state_d = MV_STEP;
        end
      end

      MV_STEP: begin
        if (oob) begin
          state_d = MV_NEXT;
        end else begin
          rd_x    = nxt_x[BOARD_BITS-1:0];
          rd_y    = nxt_y[BOARD_BITS-1:0];
          pos_x_d = nxt_x[BOARD_BITS-1:0];
          pos_y_d = nxt_y[BOARD_BITS-1:0];
          state_d = MV_EVAL;
        end
      end

      MV_EVAL: begin
        if (rd_data == opp_cell) begin
          // At most 6 interior cells on a line, so 3 bits never wrap.
          cnt_d   = cnt_q + 3'd1;
          state_d = MV_STEP;
        end else begin
          if (rd_data == own_cell && cnt_q != 3'd0) begin
            mask_d[dir_q] = 1'b1;
          end
          state_d = MV_NEXT;
        end
      end

      MV_NEXT: begin
        if (dir_q == DIR_NW) begin
          // Resolve the verdict here so it is already stable during done.
          valid_d = |mask_q;
          state_d = MV_FINISH;
        end else begin
          dir_d   = dir_q + 3'd1;
          pos_x_d = cur_x_q;
          pos_y_d = cur_y_q;
          cnt_d   = 3'd0;
          state_d = MV_STEP;
        end
      end

      MV_FINISH: begin
        done    = 1'b1;
        valid_d = |mask_q;
        busy_d  = 1'b0;
        state_d = MV_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = MV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MV_IDLE;
      start_q  <= 1'b0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      player_q <= 1'b0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      dir_q    <= 3'd0;
      cnt_q    <= 3'd0;
      mask_q   <= 8'h00;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      rd_x_q   <= '0;
      rd_y_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      player_q <= player_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      // Read address holds whatever was last driven.
      rd_x_q   <= rd_x;
      rd_y_q   <= rd_y;
    end
  end

  assign busy       = busy_q;
  assign valid_move = valid_q;
  assign flip_mask  = mask_q;

endmodule

// File: tb/tb_move_validator.sv
module tb_move_validator;
  import reversi_pkg::*;

  localparam int BB = 3;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b0;
  logic          start    = 1'b0;
  logic          player   = 1'b0;
  logic [BB-1:0] cursor_x = '0;
  logic [BB-1:0] cursor_y = '0;
  logic [BB-1:0] rd_x, rd_y;
  logic [1:0]    rd_data;
  logic          busy, done, valid_move;
  logic [7:0]    flip_mask;

  int tests = 0;
  int fails = 0;

  // board[y][x]
  logic [1:0] board [8][8];

  always #5 clk = ~clk;

  // Synchronous read port: data for the address seen at an edge appears after it.
  always @(posedge clk) rd_data <= board[rd_y][rd_x];

  move_validator #(.BOARD_BITS(BB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .player    (player),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .valid_move(valid_move),
    .flip_mask (flip_mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        board[y][x] = 2'b00;
  endtask

  task automatic set_opening();
    clear_board();
    board[3][3] = 2'b10;  // W (3,3)
    board[4][4] = 2'b10;  // W (4,4)
    board[4][3] = 2'b01;  // B (3,4)
    board[3][4] = 2'b01;  // B (4,3)
  endtask

  task automatic set_board1();
    clear_board();
    board[0][1] = 2'b10;  // W (1,0)
    board[1][1] = 2'b10;  // W (1,1)
    board[1][0] = 2'b10;  // W (0,1)
    board[0][2] = 2'b01;  // B (2,0)
    board[2][2] = 2'b01;  // B (2,2)
    board[2][0] = 2'b01;  // B (0,2)
  endtask

  // Reference: walk each ray from the cursor; a run of >=1 opponent pieces
  // closed by an own piece captures.
  function automatic logic [7:0] ref_mask(input int cx, input int cy, input logic p);
    int dxs[8];
    int dys[8];
    logic [1:0] own, opp;
    logic [7:0] m;
    int x, y, n;
    dxs = '{0, 1, 1, 1, 0, -1, -1, -1};
    dys = '{-1, -1, 0, 1, 1, 1, 0, -1};
    m = 8'h00;
    if (board[cy][cx] != 2'b00) return m;
    own = p ? 2'b10 : 2'b01;
    opp = p ? 2'b01 : 2'b10;
    for (int d = 0; d < 8; d++) begin
      x = cx + dxs[d];
      y = cy + dys[d];
      n = 0;
      while (x >= 0 && x < 8 && y >= 0 && y < 8 && board[y][x] == opp) begin
        n++;
        x += dxs[d];
        y += dys[d];
      end
      if (x >= 0 && x < 8 && y >= 0 && y < 8 && n > 0 && board[y][x] == own)
        m[d] = 1'b1;
    end
    return m;
  endfunction

  // Launch one check and wait for done; reports result, latency and whether
  // busy was up in the first cycle. Checks done is a single pulse.
  task automatic run(input int cx, input int cy, input logic p, input string tag,
                     output logic [7:0] m, output logic v, output int lat);
    logic busy1;
    bit   seen;
    @(negedge clk);
    cursor_x = BB'(cx);
    cursor_y = BB'(cy);
    player   = p;
    start    = 1'b1;
    lat   = 0;
    seen  = 1'b0;
    busy1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) busy1 = busy;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_first"}, 32'(busy1), 32'd1);
    m = flip_mask;
    v = valid_move;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         bsel;
    int         cx;
    int         cy;
    logic       p;
    logic [7:0] mask;
    logic       v;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] m;
    logic       v;
    int         lat;
    int         cnt;
    logic [7:0] exp_m;
    int         cx, cy;
    logic       p;
    int         r;

    vecs[0] = '{0, 2, 3, 1'b0, 8'h04, 1'b1};
    vecs[1] = '{0, 3, 2, 1'b0, 8'h10, 1'b1};
    vecs[2] = '{0, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{0, 3, 3, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1, 0, 0, 1'b0, 8'h1C, 1'b1};
    vecs[5] = '{0, 2, 4, 1'b1, 8'h04, 1'b1};
    vecs[6] = '{0, 4, 2, 1'b1, 8'h10, 1'b1};
    vecs[7] = '{0, 5, 4, 1'b0, 8'h40, 1'b1};

    set_opening();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid_move), 32'd0);
    chk("rst_mask", 32'(flip_mask), 32'd0);
    chk("rst_rd", {rd_y, rd_x}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].bsel == 0) set_opening();
      else set_board1();
      run(vecs[i].cx, vecs[i].cy, vecs[i].p, $sformatf("vec%0d", i), m, v, lat);
      chk($sformatf("vec%0d_mask", i), 32'(m), 32'(vecs[i].mask));
      chk($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].v));
      chk($sformatf("vec%0d_lat", i), 32'(lat <= 130), 32'd1);
      if (i == 3) begin
        // Occupied origin: fixed latency and no read past the origin.
        chk("occ_lat3", 32'(lat), 32'd3);
        chk("occ_rd", {rd_y, rd_x}, {26'd0, 3'd3, 3'd3});
      end
    end

    // Results hold until the next launch
    set_opening();
    run(2, 3, 1'b0, "hold", m, v, lat);
    repeat (5) @(negedge clk);
    chk("hold_mask", 32'(flip_mask), 32'h04);
    chk("hold_valid", 32'(valid_move), 32'd1);

    // start held high: exactly one check
    @(negedge clk);
    cursor_x = 3'd3;
    cursor_y = 3'd2;
    player   = 1'b0;
    start    = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("held_one_done", 32'(cnt), 32'd1);
    chk("held_mask", 32'(flip_mask), 32'h10);
    start = 1'b0;
    run(2, 3, 1'b0, "relaunch", m, v, lat);
    chk("relaunch_mask", 32'(m), 32'h04);

    // Reset while idle with a held result
    #2 resetn = 1'b0;
    #1;
    chk("idle_rst_mask", 32'(flip_mask), 32'd0);
    chk("idle_rst_valid", 32'(valid_move), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset in an EVAL cycle mid-scan (cursor (2,3): cycle 15 evaluates SE)
    @(negedge clk);
    cursor_x = 3'd2;
    cursor_y = 3'd3;
    player   = 1'b0;
    start    = 1'b1;
    repeat (15) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_mask", 32'(flip_mask), 32'h04);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(valid_move), 32'd0);
    chk("mid_rst_mask", 32'(flip_mask), 32'd0);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run(2, 3, 1'b0, "post_rst", m, v, lat);
    chk("post_rst_mask", 32'(m), 32'h04);
    chk("post_rst_valid", 32'(v), 32'd1);

    // Random boards against the reference
    for (int k = 0; k < 60; k++) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) begin
          r = $urandom_range(0, 9);
          board[y][x] = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        end
      cx = $urandom_range(0, 7);
      cy = $urandom_range(0, 7);
      p  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) board[cy][cx] = 2'b00;
      exp_m = ref_mask(cx, cy, p);
      run(cx, cy, p, $sformatf("rnd%0d", k), m, v, lat);
      chk($sformatf("rnd%0d_mask", k), 32'(m), 32'(exp_m));
      chk($sformatf("rnd%0d_valid", k), 32'(v), 32'(|exp_m));
      chk($sformatf("rnd%0d_lat", k), 32'(lat <= 130), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
